// File: rtl/median_filter_ctrl.sv
// Frame sequencer for the 3x3 median filter: streams 3-row columns into the filter
// and writes the (IMG_W-2)x(IMG_H-2) interior medians. Optional MF_READABLE_CHK_EN adds err.
module median_filter_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 6,
    parameter int PIX_W  = 5,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic              flt_reset,
    output logic              flt_enable,
    input  logic [PIX_W-1:0]  flt_pixel_out,
    input  logic              flt_readable,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data
`ifdef MF_READABLE_CHK_EN
    ,
    output logic              err
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CW-1:0]     C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     R_LAST = RW'(IMG_H - 2);
    localparam logic [DW-1:0]     D_LAST = DW'(LAT - 1);
    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] W_A2   = ADDR_W'(2 * IMG_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                        state_q, state_d;
    logic [RW-1:0]                 r_q, r_d;
    logic [CW-1:0]                 c_q, c_d;
    logic [ADDR_W-1:0]             base_q, base_d;
    logic [ADDR_W-1:0]             dst_q, dst_d;
    logic [DW-1:0]                 drn_q, drn_d;
    logic [LAT-1:0]                vld_pipe_q, vld_pipe_d;
    logic [LAT-1:0][ADDR_W-1:0]    addr_pipe_q, addr_pipe_d;
    logic                          rst_pulse;
    logic                          issue_vld;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RST;
            S_RST:   state_d = S_FEED;
            S_FEED:  if (r_q == R_LAST && c_q == C_LAST) state_d = S_DRAIN;
            S_DRAIN: if (drn_q == D_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem_rd     = 1'b0;
        flt_enable = 1'b0;
        rst_pulse  = 1'b0;
        mem_addr0  = '0;
        mem_addr1  = '0;
        mem_addr2  = '0;
        case (state_q)
            S_RST: begin
                busy      = 1'b1;
                rst_pulse = 1'b1;
            end
            S_FEED: begin
                busy       = 1'b1;
                mem_rd     = 1'b1;
                flt_enable = 1'b1;
                mem_addr0  = base_q + ADDR_W'(c_q);
                mem_addr1  = base_q + ADDR_W'(c_q) + W_A;
                mem_addr2  = base_q + ADDR_W'(c_q) + W_A2;
            end
            S_DRAIN: begin
                busy       = 1'b1;
                flt_enable = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign flt_reset = reset | rst_pulse;

    // ---------------- column / row counters ----------------
    // base_q tracks (r-1)*IMG_W; dst_q counts valid windows issued, which is the
    // raster-order destination address since writes land in order.
    assign issue_vld = (state_q == S_FEED) && (c_q >= CW'(2));

    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        base_d = base_q;
        dst_d  = dst_q;
        drn_d  = drn_q;
        case (state_q)
            S_RST: begin
                r_d    = RW'(1);
                c_d    = '0;
                base_d = '0;
                dst_d  = '0;
                drn_d  = '0;
            end
            S_FEED: begin
                if (c_q == C_LAST) begin
                    c_d    = '0;
                    r_d    = r_q + RW'(1);
                    base_d = base_q + W_A;
                end else begin
                    c_d = c_q + CW'(1);
                end
                if (issue_vld) dst_d = dst_q + ADDR_W'(1);
            end
            S_DRAIN: drn_d = drn_q + DW'(1);
            default: ;
        endcase
    end

    // ---------------- write tracking pipeline ----------------
    always_comb begin
        vld_pipe_d     = '0;
        addr_pipe_d    = '0;
        vld_pipe_d[0]  = issue_vld;
        addr_pipe_d[0] = dst_q;
        for (int i = 1; i < LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q         <= '0;
            c_q         <= '0;
            base_q      <= '0;
            dst_q       <= '0;
            drn_q       <= '0;
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else begin
            r_q         <= r_d;
            c_q         <= c_d;
            base_q      <= base_d;
            dst_q       <= dst_d;
            drn_q       <= drn_d;
            vld_pipe_q  <= vld_pipe_d;
            addr_pipe_q <= addr_pipe_d;
        end
    end

    assign wr_en   = vld_pipe_q[LAT-1];
    assign wr_addr = addr_pipe_q[LAT-1];
    assign wr_data = flt_pixel_out;

`ifdef MF_READABLE_CHK_EN
    // err reports in the offending write cycle and holds until the next RST
    logic err_q, err_d, err_hit;

    assign err_hit = wr_en & ~flt_readable;

    always_comb begin
        err_d = err_q | err_hit;
        if (state_q == S_RST) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q | err_hit;
`else
    logic unused_readable;
    assign unused_readable = flt_readable;
`endif

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Self-checking bench for median_filter_ctrl on a 5x5 image with a behavioural filter model.
module tb_median_filter_ctrl;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int AW   = 6;
    localparam int PW   = 5;
    localparam int LAT  = 3;
    localparam int NOUT = (W - 2) * (H - 2);
    localparam int FRAME_LEN = 21;  // start cycle to first accepted IDLE cycle

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, mem_rd, flt_reset, flt_enable, flt_readable, wr_en;
    logic [AW-1:0] mem_addr0, mem_addr1, mem_addr2, wr_addr;
    logic [PW-1:0] flt_pixel_out, wr_data;
    logic          rd_force0;
`ifdef MF_READABLE_CHK_EN
    logic          err;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    median_filter_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .flt_reset(flt_reset), .flt_enable(flt_enable), .flt_pixel_out(flt_pixel_out),
        .flt_readable(flt_readable), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef MF_READABLE_CHK_EN
        , .err(err)
`endif
    );

    // ---------------- source memory + filter model ----------------
    logic [PW-1:0] img   [64];
    logic [PW-1:0] rd_q  [3];
    logic [PW-1:0] col_q [3][3];
    logic [PW-1:0] pix_q;

    function automatic logic [PW-1:0] med9(input logic [PW-1:0] v [9]);
        logic [PW-1:0] s [9];
        logic [PW-1:0] tmp;
        s = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp;
                end
        return s[4];
    endfunction

    function automatic logic [PW-1:0] win_med();
        logic [PW-1:0] v [9];
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < 3; i++) v[j*3+i] = col_q[j][i];
        return med9(v);
    endfunction

    always @(posedge clk) begin
        if (mem_rd) begin
            rd_q[0] <= img[mem_addr0];
            rd_q[1] <= img[mem_addr1];
            rd_q[2] <= img[mem_addr2];
        end
        if (flt_reset) begin
            for (int j = 0; j < 3; j++)
                for (int i = 0; i < 3; i++) col_q[j][i] <= '0;
            pix_q <= '0;
        end else if (flt_enable) begin
            for (int i = 0; i < 3; i++) begin
                col_q[2][i] <= col_q[1][i];
                col_q[1][i] <= col_q[0][i];
                col_q[0][i] <= rd_q[i];
            end
            pix_q <= win_med();
        end
    end

    assign flt_pixel_out = pix_q;
    assign flt_readable  = ~rd_force0;

    // Reference: interior median n in raster order, straight from image coordinates
    function automatic int exp_pix(input int n);
        logic [PW-1:0] v [9];
        int oy, ox;
        oy = n / (W - 2);
        ox = n % (W - 2);
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) v[dy*3+dx] = img[(oy+dy)*W + ox + dx];
        return int'(med9(v));
    endfunction

    // Expected write cycle (relative to the start cycle) of output n of frame fr
    function automatic int exp_wcyc(input int fr, input int n);
        return FRAME_LEN * fr + 2 + (n / (W - 2)) * W + (n % (W - 2)) + 2 + LAT;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- control timing table ----------------
    typedef struct {
        int   t;
        logic busy, done, rd, en, frst;
        int   a0, a1, a2;
    } ctl_t;

    localparam int NT = 11;
    ctl_t tbl [NT];

    task automatic check_tbl(input int t);
        for (int e = 0; e < NT; e++)
            if (tbl[e].t == t) begin
                chk($sformatf("busy@%0d", t), int'(busy), int'(tbl[e].busy));
                chk($sformatf("done@%0d", t), int'(done), int'(tbl[e].done));
                chk($sformatf("mem_rd@%0d", t), int'(mem_rd), int'(tbl[e].rd));
                chk($sformatf("flt_enable@%0d", t), int'(flt_enable), int'(tbl[e].en));
                chk($sformatf("flt_reset@%0d", t), int'(flt_reset), int'(tbl[e].frst));
                chk($sformatf("mem_addr0@%0d", t), int'(mem_addr0), tbl[e].a0);
                chk($sformatf("mem_addr1@%0d", t), int'(mem_addr1), tbl[e].a1);
                chk($sformatf("mem_addr2@%0d", t), int'(mem_addr2), tbl[e].a2);
            end
    endtask

    // Runs nfr back-to-back frames (start at 0, FRAME_LEN, ...) plus optional
    // spurious start pulses, and checks every write and done against the model.
    task automatic run_frame(input string tag, input int nfr, input int spur0,
                             input int spur1, input bit use_tbl);
        int wcnt = 0;
        int dcnt = 0;
        int fr, m;
        for (int t = 0; t < FRAME_LEN * nfr + 12; t++) begin
            @(negedge clk);
            start = ((t % FRAME_LEN == 0) && (t / FRAME_LEN < nfr)) || t == spur0 || t == spur1;
            #1;
            if (use_tbl) check_tbl(t);
            if (wr_en) begin
                fr = wcnt / NOUT;
                m  = wcnt % NOUT;
                if (fr < nfr) begin
                    chk({tag, " wr_addr"}, int'(wr_addr), m);
                    chk({tag, " wr_data"}, int'(wr_data), exp_pix(m));
                    chk({tag, " wr_cycle"}, t, exp_wcyc(fr, m));
                end
                wcnt++;
            end
            if (done) begin
                chk({tag, " done_cycle"}, t, FRAME_LEN * dcnt + 20);
                dcnt++;
            end
        end
        start = 1'b0;
        chk({tag, " write_count"}, wcnt, NOUT * nfr);
        chk({tag, " done_count"}, dcnt, nfr);
    endtask

    initial begin
        int wr_seen, dn_seen, bz_seen;
        reset     = 1'b1;
        start     = 1'b0;
        rd_force0 = 1'b0;
        for (int i = 0; i < 64; i++) img[i] = PW'(i);

        tbl[0]  = '{t:0,  busy:0, done:0, rd:0, en:0, frst:0, a0:0,  a1:0,  a2:0};
        tbl[1]  = '{t:1,  busy:1, done:0, rd:0, en:0, frst:1, a0:0,  a1:0,  a2:0};
        tbl[2]  = '{t:2,  busy:1, done:0, rd:1, en:1, frst:0, a0:0,  a1:5,  a2:10};
        tbl[3]  = '{t:6,  busy:1, done:0, rd:1, en:1, frst:0, a0:4,  a1:9,  a2:14};
        tbl[4]  = '{t:7,  busy:1, done:0, rd:1, en:1, frst:0, a0:5,  a1:10, a2:15};
        tbl[5]  = '{t:13, busy:1, done:0, rd:1, en:1, frst:0, a0:11, a1:16, a2:21};
        tbl[6]  = '{t:16, busy:1, done:0, rd:1, en:1, frst:0, a0:14, a1:19, a2:24};
        tbl[7]  = '{t:17, busy:1, done:0, rd:0, en:1, frst:0, a0:0,  a1:0,  a2:0};
        tbl[8]  = '{t:19, busy:1, done:0, rd:0, en:1, frst:0, a0:0,  a1:0,  a2:0};
        tbl[9]  = '{t:20, busy:0, done:1, rd:0, en:0, frst:0, a0:0,  a1:0,  a2:0};
        tbl[10] = '{t:21, busy:0, done:0, rd:0, en:0, frst:0, a0:0,  a1:0,  a2:0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst mem_rd", int'(mem_rd), 0);
        chk("rst flt_enable", int'(flt_enable), 0);
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst flt_reset", int'(flt_reset), 1);
        chk("rst mem_addr1", int'(mem_addr1), 0);
        reset = 1'b0;
        #1 chk("idle flt_reset", int'(flt_reset), 0);

        // ramp image with full control-timing table
        run_frame("ramp", 1, -1, -1, 1'b1);

        // constant 10 with a single hot pixel in the centre
        for (int i = 0; i < W * H; i++) img[i] = PW'(10);
        img[2*W+2] = PW'(31);
        run_frame("spot", 1, -1, -1, 1'b0);

        // spurious start during FEED and during DONE
        for (int i = 0; i < W * H; i++) img[i] = PW'($urandom_range(0, 31));
        run_frame("spur", 1, 5, 20, 1'b0);

        // start on the first IDLE cycle after DONE
        run_frame("b2b", 2, -1, -1, 1'b0);

        // random images
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < W * H; i++) img[i] = PW'($urandom_range(0, 31));
            run_frame($sformatf("rand%0d", k), 1, -1, -1, 1'b0);
        end

        // reset in the middle of FEED
        for (int t = 0; t <= 8; t++) begin
            @(negedge clk);
            start = (t == 0);
            if (t == 8) reset = 1'b1;
        end
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst mem_rd", int'(mem_rd), 0);
        chk("midrst flt_enable", int'(flt_enable), 0);
        chk("midrst wr_en", int'(wr_en), 0);
        chk("midrst flt_reset", int'(flt_reset), 1);
        chk("midrst mem_addr2", int'(mem_addr2), 0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        wr_seen = 0;
        dn_seen = 0;
        bz_seen = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            #1;
            wr_seen += int'(wr_en);
            dn_seen += int'(done);
            bz_seen += int'(busy);
        end
        chk("postrst writes", wr_seen, 0);
        chk("postrst done", dn_seen, 0);
        chk("postrst busy", bz_seen, 0);
        run_frame("afterrst", 1, -1, -1, 1'b0);

`ifdef MF_READABLE_CHK_EN
        chk("err clean", int'(err), 0);
        rd_force0 = 1'b1;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            start = (t == 0);
            #1;
            if (t == exp_wcyc(0, 0) - 1) chk("err before write", int'(err), 0);
            if (t == exp_wcyc(0, 0)) chk("err first write", int'(err), 1);
        end
        chk("err held", int'(err), 1);
        rd_force0 = 1'b0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            start = (t == 0);
            #1;
            if (t == 2) chk("err cleared by rst", int'(err), 0);
        end
        chk("err good frame", int'(err), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
